// File: rtl/jesd204b_gt_reset_sequencer.sv
// JESD204B RX transceiver reset/bring-up sequencer. Runs in the free-running clock domain.
// Asynchronous inputs cost 2 cycles of synchroniser latency. Outputs are registered from next-state, and there is no backpressure.
module jesd204b_gt_reset_sequencer #(
    parameter int NUM_LANES       = 1,
    parameter int CNT_WIDTH       = 16,
    parameter int STARTUP_TIME    = 100,
    parameter int PGOOD_DEBOUNCE  = 16,
    parameter int RESET_HOLD_TIME = 4000,
    parameter int DONE_TIMEOUT    = 65535,
    parameter int MAX_RETRIES     = 3
) (
    input  logic                 i_gtwiz_reset_clk_freerun_in,
    input  logic                 i_rst,
    input  logic [NUM_LANES-1:0] i_gtpowergood_out,
    input  logic                 i_gtwiz_reset_rx_done_out,
    input  logic                 i_link_fail_req,
    input  logic                 i_restart,
    output logic                 o_gtwiz_reset_all_in,
    output logic                 o_gtwiz_userclk_rx_active_in,
    output logic                 o_reset_done,
    output logic                 o_fail,
    output logic [2:0]           o_state,
    output logic [3:0]           o_retry_cnt
);

    localparam logic [2:0] ST_PWR_WAIT = 3'd0;
    localparam logic [2:0] ST_HOLD     = 3'd1;
    localparam logic [2:0] ST_REL_WAIT = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_RETRY    = 3'd4;
    localparam logic [2:0] ST_FAIL     = 3'd5;

    localparam logic [CNT_WIDTH-1:0] STARTUP_LAST = CNT_WIDTH'(STARTUP_TIME);
    localparam logic [CNT_WIDTH-1:0] DEB_LAST     = CNT_WIDTH'(PGOOD_DEBOUNCE - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RESET_HOLD_TIME - 1);
    localparam logic [CNT_WIDTH-1:0] DONE_LAST    = CNT_WIDTH'(DONE_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [3:0]           RETRY_LIMIT  = 4'(MAX_RETRIES);

    logic [NUM_LANES-1:0] pg_meta_q, pg_sync_q;
    logic                 done_meta_q, done_sync_q;
    logic                 lf_meta_q, lf_sync_q, lf_prev_q;
    logic                 rs_meta_q, rs_sync_q, rs_prev_q;

    logic [CNT_WIDTH-1:0] startup_cnt_q, startup_cnt_d;
    logic [CNT_WIDTH-1:0] timer_q, timer_d;
    logic [2:0]           state_q, state_d;
    logic [3:0]           retry_q, retry_d;
    logic                 reset_all_q, reset_done_q, fail_q;

    logic pg_all, lf_rise, rs_rise;

    always_ff @(posedge i_gtwiz_reset_clk_freerun_in or posedge i_rst) begin
        if (i_rst) begin
            pg_meta_q   <= '0;
            pg_sync_q   <= '0;
            done_meta_q <= 1'b0;
            done_sync_q <= 1'b0;
            lf_meta_q   <= 1'b0;
            lf_sync_q   <= 1'b0;
            lf_prev_q   <= 1'b0;
            rs_meta_q   <= 1'b0;
            rs_sync_q   <= 1'b0;
            rs_prev_q   <= 1'b0;
        end else begin
            pg_meta_q   <= i_gtpowergood_out;
            pg_sync_q   <= pg_meta_q;
            done_meta_q <= i_gtwiz_reset_rx_done_out;
            done_sync_q <= done_meta_q;
            lf_meta_q   <= i_link_fail_req;
            lf_sync_q   <= lf_meta_q;
            lf_prev_q   <= lf_sync_q;
            rs_meta_q   <= i_restart;
            rs_sync_q   <= rs_meta_q;
            rs_prev_q   <= rs_sync_q;
        end
    end

    assign pg_all  = &pg_sync_q;
    assign lf_rise = lf_sync_q & ~lf_prev_q;
    assign rs_rise = rs_sync_q & ~rs_prev_q;

    // Startup timer is independent of the FSM and saturates, so the user clock flag is sticky until reset.
    assign startup_cnt_d = (startup_cnt_q == STARTUP_LAST) ? startup_cnt_q : startup_cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        case (state_q)
            ST_PWR_WAIT: begin
                if (!pg_all) begin
                    timer_d = '0;
                end else if (timer_q == DEB_LAST) begin
                    state_d = ST_HOLD;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!pg_all) begin
                    state_d = ST_PWR_WAIT;
                    timer_d = '0;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = ST_REL_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            ST_REL_WAIT: begin
                if (!pg_all) begin
                    state_d = ST_PWR_WAIT;
                    timer_d = '0;
                end else if (done_sync_q) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                    retry_d = '0;
                end else if (timer_q == DONE_LAST) begin
                    state_d = ST_RETRY;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                timer_d = '0;
                if (!pg_all) begin
                    state_d = ST_PWR_WAIT;
                end else if (!done_sync_q || lf_rise) begin
                    state_d = ST_RETRY;
                end
            end
            ST_RETRY: begin
                timer_d = '0;
                retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_HOLD;
            end
            ST_FAIL: begin
                timer_d = '0;
                if (rs_rise) begin
                    state_d = ST_PWR_WAIT;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_PWR_WAIT;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change in the same cycle as o_state.
    always_ff @(posedge i_gtwiz_reset_clk_freerun_in or posedge i_rst) begin
        if (i_rst) begin
            startup_cnt_q <= '0;
            timer_q       <= '0;
            state_q       <= ST_PWR_WAIT;
            retry_q       <= '0;
            reset_all_q   <= 1'b1;
            reset_done_q  <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            startup_cnt_q <= startup_cnt_d;
            timer_q       <= timer_d;
            state_q       <= state_d;
            retry_q       <= retry_d;
            reset_all_q   <= (state_d != ST_REL_WAIT) && (state_d != ST_RUN);
            reset_done_q  <= (state_d == ST_RUN);
            fail_q        <= (state_d == ST_FAIL);
        end
    end

    assign o_gtwiz_reset_all_in         = reset_all_q;
    assign o_gtwiz_userclk_rx_active_in = (startup_cnt_q == STARTUP_LAST);
    assign o_reset_done                 = reset_done_q;
    assign o_fail                       = fail_q;
    assign o_state                      = state_q;
    assign o_retry_cnt                  = retry_q;

endmodule

// File: tb/tb_jesd204b_gt_reset_sequencer.sv
// Bench for jesd204b_gt_reset_sequencer: expected state transitions are queued with their arrival cycle
// when stimulus is driven, and a negedge monitor pops and checks them as the DUT changes state.
module tb_jesd204b_gt_reset_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] pgood;
    logic       rx_done;
    logic       link_fail;
    logic       restart;
    logic       reset_all;
    logic       userclk;
    logic       reset_done;
    logic       fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    jesd204b_gt_reset_sequencer #(
        .NUM_LANES       (2),
        .CNT_WIDTH       (16),
        .STARTUP_TIME    (10),
        .PGOOD_DEBOUNCE  (4),
        .RESET_HOLD_TIME (20),
        .DONE_TIMEOUT    (50),
        .MAX_RETRIES     (2)
    ) dut (
        .i_gtwiz_reset_clk_freerun_in (clk),
        .i_rst                        (rst),
        .i_gtpowergood_out            (pgood),
        .i_gtwiz_reset_rx_done_out    (rx_done),
        .i_link_fail_req              (link_fail),
        .i_restart                    (restart),
        .o_gtwiz_reset_all_in         (reset_all),
        .o_gtwiz_userclk_rx_active_in (userclk),
        .o_reset_done                 (reset_done),
        .o_fail                       (fail),
        .o_state                      (state),
        .o_retry_cnt                  (retry_cnt)
    );

    localparam int S_PWR = 0, S_HOLD = 1, S_REL = 2, S_RUN = 3, S_RETRY = 4, S_FAIL = 5;

    typedef struct {
        string tag;
        int    st;
        int    at;
        int    rc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   prev_state = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc = 0;
        else     cyc++;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic push(input string tag, input int st, input int at, input int rc);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.at  = at;
        e.rc  = rc;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_state = int'(state);
        end else if (int'(state) != prev_state) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_transition", int'(state), prev_state);
            end else begin
                mon_e = sb.pop_front();
                check_eq({mon_e.tag, "_state"},      int'(state), mon_e.st);
                check_eq({mon_e.tag, "_cycle"},      cyc, mon_e.at);
                check_eq({mon_e.tag, "_reset_all"},  int'(reset_all),
                         (mon_e.st == S_REL || mon_e.st == S_RUN) ? 0 : 1);
                check_eq({mon_e.tag, "_reset_done"}, int'(reset_done), (mon_e.st == S_RUN) ? 1 : 0);
                check_eq({mon_e.tag, "_fail"},       int'(fail), (mon_e.st == S_FAIL) ? 1 : 0);
                check_eq({mon_e.tag, "_retry_cnt"},  int'(retry_cnt), mon_e.rc);
            end
            prev_state = int'(state);
        end
    end

    initial begin
        rst       = 1'b1;
        pgood     = 2'b00;
        rx_done   = 1'b0;
        link_fail = 1'b0;
        restart   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_reset_all",  int'(reset_all), 1);
        check_eq("rst_userclk",    int'(userclk), 0);
        check_eq("rst_reset_done", int'(reset_done), 0);
        check_eq("rst_fail",       int'(fail), 0);
        check_eq("rst_state",      int'(state), S_PWR);
        check_eq("rst_retry",      int'(retry_cnt), 0);
        rst = 1'b0;

        // Nominal bring-up: HOLD 2 sync + 4 debounce cycles after pgood, release 20 later.
        wait_cyc(2);
        pgood = 2'b11;
        push("nom_hold", S_HOLD, 8, 0);
        push("nom_rel",  S_REL, 28, 0);
        wait_cyc(9);
        check_eq("userclk_c9", int'(userclk), 0);
        wait_cyc(10);
        check_eq("userclk_c10", int'(userclk), 1);
        wait_cyc(33);
        rx_done = 1'b1;
        push("nom_run", S_RUN, 36, 0);
        wait_cyc(40);
        check_eq("nom_run_done", int'(reset_done), 1);

        // Link re-reset: 3-cycle request gives exactly one RETRY and a return to RUN.
        link_fail = 1'b1;
        push("lf_retry", S_RETRY, 43, 0);
        push("lf_hold",  S_HOLD,  44, 1);
        push("lf_rel",   S_REL,   64, 1);
        push("lf_run",   S_RUN,   65, 0);
        wait_cyc(43);
        link_fail = 1'b0;
        wait_cyc(70);
        check_eq("lf_userclk_sticky", int'(userclk), 1);

        // Lane0 power loss together with rx_done fall: power loss takes priority.
        pgood   = 2'b10;
        rx_done = 1'b0;
        push("pl_pwr", S_PWR, 73, 0);

        // Debounce glitch on lane1 at count 2, then two done timeouts into FAIL.
        wait_cyc(80);
        pgood = 2'b11;
        push("gl_hold",   S_HOLD,   89, 0);
        push("to_rel1",   S_REL,   109, 0);
        push("to_retry1", S_RETRY, 159, 0);
        push("to_hold2",  S_HOLD,  160, 1);
        push("to_rel2",   S_REL,   180, 1);
        push("to_retry2", S_RETRY, 230, 1);
        push("to_fail",   S_FAIL,  231, 2);
        wait_cyc(82);
        pgood = 2'b01;
        wait_cyc(83);
        pgood = 2'b11;

        // Power-good is ignored while failed.
        wait_cyc(235);
        pgood = 2'b00;
        wait_cyc(245);
        pgood = 2'b11;
        wait_cyc(250);
        check_eq("fail_out",   int'(fail), 1);
        check_eq("fail_state", int'(state), S_FAIL);
        check_eq("fail_retry", int'(retry_cnt), 2);

        // Restart from FAIL and bring the link back up.
        restart = 1'b1;
        push("rs_pwr",  S_PWR,  253, 0);
        push("rs_hold", S_HOLD, 257, 0);
        push("rs_rel",  S_REL,  277, 0);
        push("rs_run",  S_RUN,  282, 0);
        wait_cyc(255);
        restart = 1'b0;
        wait_cyc(279);
        rx_done = 1'b1;
        wait_cyc(290);

        // Power loss in RUN, recover into HOLD, then reset asynchronously mid-HOLD.
        pgood = 2'b10;
        push("pl2_pwr", S_PWR, 293, 0);
        wait_cyc(293);
        pgood = 2'b11;
        push("pl2_hold", S_HOLD, 299, 0);
        wait_cyc(305);
        check_eq("pre_rst_state", int'(state), S_HOLD);
        rst = 1'b1;
        #1;
        check_eq("arst_reset_all",  int'(reset_all), 1);
        check_eq("arst_userclk",    int'(userclk), 0);
        check_eq("arst_reset_done", int'(reset_done), 0);
        check_eq("arst_fail",       int'(fail), 0);
        check_eq("arst_state",      int'(state), S_PWR);
        check_eq("arst_retry",      int'(retry_cnt), 0);
        repeat (3) @(negedge clk);
        check_eq("sb_pending", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
